rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters: the instruction-fetch stage (IF port) and the data-side constant-load path (D port).
- Grants at most one access per cycle and drives the ROM address from the winner.
- Registers the ROM word into a per-port output register and signals a one-cycle valid pulse.
- Sits between the fetch/memory stages and the ROM; all ROM accesses in the CPU go through it.

Parameters:
- ADDR_W, default `ROM_ADDR_WIDTH: byte-address width of every address port.
- DATA_W, default `ROM_DATA_WIDTH: word width of every data port.
- MAX_DATA_WAIT, default 4: number of consecutive denied D-port cycles after which the D port is forced to win. Legal range 1..15.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_if_req  input  1  fetch request; held until granted.
- i_if_addr  input  ADDR_W  fetch byte address; stable while i_if_req is high.
- o_if_gnt  output  1  combinational grant to the fetch port this cycle.
- o_if_valid  output  1  registered; o_if_data is valid this cycle.
- o_if_data  output  DATA_W  registered fetch word.
- i_d_req  input  1  data request; held until granted.
- i_d_addr  input  ADDR_W  data byte address.
- o_d_gnt  output  1  combinational grant to the data port.
- o_d_valid  output  1  registered; o_d_data is valid.
- o_d_data  output  DATA_W  registered data word.
- o_d_misalign  output  1  registered; pulses with o_d_valid when i_d_addr[1:0] != 0.
- o_rom_addr  output  ADDR_W  to the ROM address input; the ROM indexes internally by address >> 2.
- i_rom_data  input  DATA_W  from the ROM data output; combinational in o_rom_addr.

Behaviour:
Grant logic (combinational):
- Only i_if_req: o_if_gnt = 1.
- Only i_d_req: o_d_gnt = 1.
- Both requesting: fetch wins, unless wait_cnt == MAX_DATA_WAIT, in which case data wins.
- Neither requesting: no grant, and o_rom_addr = 0.
- o_if_gnt and o_d_gnt are never high together.
- o_rom_addr = the granted port's address.

wait_cnt (4-bit register):
- Resets to 0.
- Increments each cycle i_d_req = 1 and o_d_gnt = 0.
- Clears on a D grant or whenever i_d_req = 0.
- Saturates at MAX_DATA_WAIT.

Response timing:
- A grant in cycle t causes i_rom_data to be captured into the granted port's data register at the end of cycle t.
- The port's valid is high for exactly cycle t+1 (latency 1).
- Data registers hold their last value until that port's next capture.
- Back-to-back grants to the same port produce a valid every cycle.

Misalignment:
- A D access with addr[1:0] != 0 is still performed; the ROM returns the word-aligned word.
- o_d_misalign = 1 in the same cycle as o_d_valid for that access.
- Fetch misalignment is not flagged.

Requester rules:
- A requester keeps req and addr stable until it sees gnt.
- It may deassert req in the cycle after gnt.
- Dropping req before gnt is legal; wait_cnt then clears.

Reset:
- While i_rst = 1, all registered outputs (valids, data registers, misalign) clear to 0 and wait_cnt = 0.
- gnt outputs remain combinational, but a grant in a reset cycle produces no valid in the following cycle.
- Reset mid-operation discards any pending response.

Optional Feature:
- Macro ROM_ARB_STATS_EN.
- When defined, adds output ports:
  - o_stat_conflicts (32-bit): counts cycles with both requests high.
  - o_stat_forced (32-bit): counts forced D grants.
  - Both counters clear on i_rst and wrap modulo 2^32.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
1. Reset: hold i_rst = 1 for 3 cycles with both reqs high -> o_if_valid = o_d_valid = 0, data = 0 in the cycle after reset releases; then the first IF valid appears.
2. Fetch only: i_if_req = 1, addr 0x0,0x4,0x8 on consecutive cycles -> o_rom_addr follows the same cycle; o_if_valid = 1 with mem[0],mem[1],mem[2] in cycles t+1..t+3.
3. Conflict: both reqs held, MAX_DATA_WAIT = 4 -> IF granted 4 cycles, D granted in cycle 5 (o_d_valid in cycle 6), wait_cnt back to 0.
4. D alone at addr 0x12 -> o_d_gnt same cycle; next cycle o_d_valid = 1, o_d_data = mem[4], o_d_misalign = 1.
5. D req dropped after 3 denied cycles, then reasserted -> the count restarts from 0 and the forced grant arrives only after 4 further denials.
6. With ROM_ARB_STATS_EN: scenario 3 -> o_stat_conflicts = 5, o_stat_forced = 1.

Source files
------------

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one combinational instruction ROM between the instruction-fetch port
// (IF) and the data-side constant-load port (D). At most one port is granted
// per cycle. The granted port's address drives the ROM, and the returned word
// is captured into that port's output register with a one-cycle valid pulse.
// IF normally wins a conflict. After MAX_DATA_WAIT consecutive denied D cycles,
// D is forced to win.
//
// Optional feature: define ROM_ARB_STATS_EN to add the conflict/forced-grant
// statistics counters and their output ports.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_if_req / i_if_addr    fetch request and byte address
//   o_if_gnt                combinational fetch grant
//   o_if_valid / o_if_data  registered fetch response (latency 1)
//   i_d_req / i_d_addr      data request and byte address
//   o_d_gnt                 combinational data grant
//   o_d_valid / o_d_data    registered data response (latency 1)
//   o_d_misalign            registered, pulses with o_d_valid on addr[1:0] != 0
//   o_rom_addr / i_rom_data ROM address out, combinational ROM word in
//   o_stat_conflicts        (ROM_ARB_STATS_EN) cycles with both requests high
//   o_stat_forced           (ROM_ARB_STATS_EN) forced D grants
// -----------------------------------------------------------------------------
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 32
`endif
`ifndef ROM_DATA_WIDTH
`define ROM_DATA_WIDTH 32
`endif

module rom_arbiter #(
    parameter int ADDR_W        = `ROM_ADDR_WIDTH,
    parameter int DATA_W        = `ROM_DATA_WIDTH,
    parameter int MAX_DATA_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_data,

    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    output logic              o_d_gnt,
    output logic              o_d_valid,
    output logic [DATA_W-1:0] o_d_data,
    output logic              o_d_misalign,

    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [31:0]       o_stat_conflicts,
    output logic [31:0]       o_stat_forced
`endif
);

    localparam logic [3:0] MAX_WAIT = 4'(MAX_DATA_WAIT);

    logic [3:0]        wait_cnt_q,   wait_cnt_d;
    logic              if_valid_q,   if_valid_d;
    logic [DATA_W-1:0] if_data_q,    if_data_d;
    logic              d_valid_q,    d_valid_d;
    logic [DATA_W-1:0] d_data_q,     d_data_d;
    logic              d_misalign_q, d_misalign_d;

    logic if_gnt;
    logic d_gnt;
    logic d_forced;

    // Grant and ROM address. When the starvation count has reached its limit,
    // D wins a conflict. Otherwise IF has priority.
    always_comb begin
        d_forced   = (wait_cnt_q == MAX_WAIT);
        d_gnt      = i_d_req & (~i_if_req | d_forced);
        if_gnt     = i_if_req & ~d_gnt;
        o_rom_addr = '0;
        if (d_gnt) begin
            o_rom_addr = i_d_addr;
        end else if (if_gnt) begin
            o_rom_addr = i_if_addr;
        end
    end

    // Next-state logic for the response registers and the starvation counter.
    always_comb begin
        // NOTE: every signal gets a default first, so the incomplete if-chains below cannot infer latches.
        wait_cnt_d   = wait_cnt_q;
        if_valid_d   = if_gnt;
        if_data_d    = if_data_q;
        d_valid_d    = d_gnt;
        d_data_d     = d_data_q;
        d_misalign_d = d_gnt & (i_d_addr[1:0] != 2'b00);

        if (if_gnt) begin
            if_data_d = i_rom_data;
        end
        if (d_gnt) begin
            d_data_d = i_rom_data;
        end

        // The count tracks consecutive denials only. Any grant, or any cycle
        // without a request, restarts it.
        if (!i_d_req || d_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt_q   <= 4'd0;
            if_valid_q   <= 1'b0;
            if_data_q    <= '0;
            d_valid_q    <= 1'b0;
            d_data_q     <= '0;
            d_misalign_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            if_valid_q   <= if_valid_d;
            if_data_q    <= if_data_d;
            d_valid_q    <= d_valid_d;
            d_data_q     <= d_data_d;
            d_misalign_q <= d_misalign_d;
        end
    end

    assign o_if_gnt     = if_gnt;
    assign o_d_gnt      = d_gnt;
    assign o_if_valid   = if_valid_q;
    assign o_if_data    = if_data_q;
    assign o_d_valid    = d_valid_q;
    assign o_d_data     = d_data_q;
    assign o_d_misalign = d_misalign_q;

`ifdef ROM_ARB_STATS_EN
    logic [31:0] conflicts_q, conflicts_d;
    logic [31:0] forced_q,    forced_d;

    // A forced grant is a D win while IF is also requesting. A D grant with no
    // competing IF request is an ordinary grant.
    always_comb begin
        conflicts_d = conflicts_q;
        forced_d    = forced_q;
        if (i_if_req && i_d_req) begin
            conflicts_d = conflicts_q + 32'd1;
        end
        if (d_gnt && i_if_req) begin
            forced_d = forced_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            conflicts_q <= 32'd0;
            forced_q    <= 32'd0;
        end else begin
            conflicts_q <= conflicts_d;
            forced_q    <= forced_d;
        end
    end

    assign o_stat_conflicts = conflicts_q;
    assign o_stat_forced    = forced_q;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Self-checking bench for rom_arbiter. A ROM array is modelled in the bench.
// A behavioural model is evaluated on every falling edge and compared against
// all DUT outputs. The model computes the grant, starvation streak and
// responses directly from the arbitration rules.
//
// Directed scenarios pin the expected values with literals. A randomized phase
// follows. Its requesters hold req/addr until they are granted, and they
// occasionally drop a request early or assert reset.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b1;
    logic [ADDR_W-1:0] if_addr = 8'h08;
    logic              d_req = 1'b1;
    logic [ADDR_W-1:0] d_addr = 8'h00;

    logic              o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_d_misalign;
    logic [DATA_W-1:0] o_if_data, o_d_data, rom_data;
    logic [ADDR_W-1:0] o_rom_addr;
`ifdef ROM_ARB_STATS_EN
    logic [31:0]       stat_conflicts, stat_forced;
`endif

    logic [DATA_W-1:0] mem [64];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Combinational ROM: word index is the byte address divided by 4.
    assign rom_data = mem[o_rom_addr[7:2]];

    rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_WAIT(MAX_WAIT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
        .o_if_valid(o_if_valid), .o_if_data(o_if_data),
        .i_d_req(d_req), .i_d_addr(d_addr), .o_d_gnt(o_d_gnt),
        .o_d_valid(o_d_valid), .o_d_data(o_d_data), .o_d_misalign(o_d_misalign),
        .o_rom_addr(o_rom_addr), .i_rom_data(rom_data)
`ifdef ROM_ARB_STATS_EN
        , .o_stat_conflicts(stat_conflicts), .o_stat_forced(stat_forced)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                model_on = 1'b0;
    int                streak = 0;
    bit                m_if_gnt, m_d_gnt;
    logic [ADDR_W-1:0] m_addr;
    bit                e_if_valid = 0, e_d_valid = 0, e_mis = 0;
    logic [DATA_W-1:0] e_if_data = '0, e_d_data = '0;
    longint            e_conf = 0, e_forced = 0;

    always @(negedge clk) begin
        if (model_on) begin
            // D wins when it is alone, or when it has already been denied MAX_WAIT times in a row.
            m_d_gnt  = d_req && (!if_req || streak == MAX_WAIT);
            m_if_gnt = if_req && !m_d_gnt;
            m_addr   = m_d_gnt ? d_addr : (m_if_gnt ? if_addr : 8'h00);

            check("if_gnt",     o_if_gnt,     m_if_gnt);
            check("d_gnt",      o_d_gnt,      m_d_gnt);
            check("rom_addr",   o_rom_addr,   m_addr);
            check("if_valid",   o_if_valid,   e_if_valid);
            check("if_data",    o_if_data,    e_if_data);
            check("d_valid",    o_d_valid,    e_d_valid);
            check("d_data",     o_d_data,     e_d_data);
            check("d_misalign", o_d_misalign, e_mis);
`ifdef ROM_ARB_STATS_EN
            check("stat_conflicts", stat_conflicts, e_conf);
            check("stat_forced",    stat_forced,    e_forced);
`endif

            // Expected state after the coming rising edge.
            if (rst) begin
                streak = 0; e_if_valid = 0; e_d_valid = 0; e_mis = 0;
                e_if_data = '0; e_d_data = '0; e_conf = 0; e_forced = 0;
            end else begin
                e_if_valid = m_if_gnt;
                e_d_valid  = m_d_gnt;
                if (m_if_gnt) e_if_data = mem[if_addr / 4];
                if (m_d_gnt)  e_d_data  = mem[d_addr / 4];
                e_mis      = m_d_gnt && (d_addr % 4 != 0);
                if (d_req && !m_d_gnt) streak = (streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1;
                else                   streak = 0;
                if (if_req && d_req)   e_conf   = (e_conf + 1) % (64'd1 << 32);
                if (m_d_gnt && if_req) e_forced = (e_forced + 1) % (64'd1 << 32);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds both requests until D is granted. Returns the number of denied D cycles.
    task automatic both_until_d(output int denied, output bit got);
        denied = 0;
        got    = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (o_d_gnt) got = 1'b1;
            else         denied++;
            step();
        end
    endtask

    int den;
    bit got;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {8'hC0, 8'(i), 16'hBEEF};

        // 1. Reset for three cycles with both requests high.
        @(posedge clk);
        #1 model_on = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("s1_if_valid0", o_if_valid, 1'b0);
        check("s1_d_valid0",  o_d_valid,  1'b0);
        check("s1_if_data0",  o_if_data,  32'h0);
        check("s1_d_data0",   o_d_data,   32'h0);
        check("s1_if_gnt",    o_if_gnt,   1'b1);
        step();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("s1_if_valid1", o_if_valid, 1'b1);
        check("s1_if_data1",  o_if_data,  32'hC002BEEF);

        // 2. Fetch only, addresses 0x0, 0x4, 0x8 back to back.
        step();
        if_req = 1'b1; if_addr = 8'h00;
        @(negedge clk);
        check("s2_addr0", o_rom_addr, 8'h00);
        step();
        if_addr = 8'h04;
        @(negedge clk);
        check("s2_addr1", o_rom_addr, 8'h04);
        check("s2_data0", o_if_data,  32'hC000BEEF);
        step();
        if_addr = 8'h08;
        @(negedge clk);
        check("s2_addr2", o_rom_addr, 8'h08);
        check("s2_data1", o_if_data,  32'hC001BEEF);
        step();
        if_req = 1'b0;
        @(negedge clk);
        check("s2_valid2", o_if_valid, 1'b1);
        check("s2_data2",  o_if_data,  32'hC002BEEF);

        // 3. Conflict: IF wins four times, then D is forced.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_addr = 8'h20;
        both_until_d(den, got);
        check("s3_got_d",   got, 1'b1);
        check("s3_denied",  den, 4);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("s3_d_valid", o_d_valid,    1'b1);
        check("s3_d_data",  o_d_data,     32'hC008BEEF);
        check("s3_mis",     o_d_misalign, 1'b0);
`ifdef ROM_ARB_STATS_EN
        check("s6_conflicts", stat_conflicts, 32'd5);
        check("s6_forced",    stat_forced,    32'd1);
`endif

        // 4. Misaligned D access.
        step();
        d_req = 1'b1; d_addr = 8'h12;
        @(negedge clk);
        check("s4_d_gnt", o_d_gnt,    1'b1);
        check("s4_addr",  o_rom_addr, 8'h12);
        step();
        d_req = 1'b0;
        @(negedge clk);
        check("s4_d_valid", o_d_valid,    1'b1);
        check("s4_d_data",  o_d_data,     32'hC004BEEF);
        check("s4_mis",     o_d_misalign, 1'b1);

        // 5. D dropped after three denials: the count restarts from zero.
        step();
        if_req = 1'b1; if_addr = 8'h04; d_req = 1'b1; d_addr = 8'h08;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s5_denied", o_d_gnt, 1'b0);
            step();
        end
        d_req = 1'b0;
        step();
        d_req = 1'b1;
        both_until_d(den, got);
        check("s5_got_d",  got, 1'b1);
        check("s5_denied4", den, 4);
        if_req = 1'b0; d_req = 1'b0;
        step();

        // Randomized phase. Requesters obey the hold-until-granted rule.
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req || m_d_gnt) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 31) == 0) begin
                d_req = 1'b0;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        step();
        step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
